// File: rtl/dma_2d_sched_if.sv
// Chunk command channel between the 2D scheduler and the data mover.
// The scheduler is the master: it presents chunk commands and receives
// ready/done feedback from the mover.
interface dma_2d_sched_if;
  logic        ck_valid;
  logic        ck_ready;
  logic [31:0] ck_src;
  logic [31:0] ck_dst;
  logic [15:0] ck_len;
  logic        ck_done;

  modport master (
    output ck_valid, ck_src, ck_dst, ck_len,
    input  ck_ready, ck_done
  );

  modport slave (
    input  ck_valid, ck_src, ck_dst, ck_len,
    output ck_ready, ck_done
  );
endinterface

// File: rtl/dma_2d_sched.sv
// 2D DMA scheduler: splits a (xsize x ysize) strided transfer into chunk
// commands of at most BURST_BYTES, bounded by MAX_OUTS chunks in flight,
// and pulses cmd_end once every issued chunk has reported done.
//
// state | meaning
// IDLE  | waiting for cmd_sof
// ISSUE | presenting chunk commands line by line
// DRAIN | all chunks accepted, waiting for outstanding dones
// END   | command complete, cmd_end pulses on the following cycle
module dma_2d_sched #(
  parameter int BURST_BYTES = 64,
  parameter int MAX_OUTS    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_sof,
  input  logic [31:0]           cfg_sar,
  input  logic [31:0]           cfg_dar,
  input  logic [15:0]           cfg_trans_xsize,
  input  logic [15:0]           cfg_trans_ysize,
  input  logic [15:0]           cfg_sa_ystep,
  input  logic [15:0]           cfg_da_ystep,
  input  logic                  cfg_dma_halt,
  output logic                  cmd_end,
  output logic                  sched_busy,
  dma_2d_sched_if.master        ck
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_END   = 2'd3
  } state_t;

  localparam logic [16:0] BURST = 17'(BURST_BYTES);
  localparam logic [3:0]  MAX_O = 4'(MAX_OUTS);

  state_t      state;
  logic [15:0] xsize;
  logic [15:0] sa_ystep;
  logic [15:0] da_ystep;
  logic [15:0] x_off;
  logic [15:0] lines_left;
  logic [31:0] line_src;
  logic [31:0] line_dst;
  logic [3:0]  outs;
  logic        final_chunk;

  logic        xfer;
  logic        done_eff;
  logic [3:0]  outs_next;
  logic [15:0] rem;
  logic [15:0] len;
  logic        last_x;
  logic        can_present;

  // Chunk geometry for the next presentation and the in-flight count after this cycle.
  always_comb begin
    xfer        = ck.ck_valid & ck.ck_ready;
    done_eff    = ck.ck_done & (outs != 4'd0);
    outs_next   = outs + {3'd0, xfer} - {3'd0, done_eff};
    rem         = xsize - x_off;
    last_x      = ({1'b0, rem} <= BURST);
    len         = last_x ? rem : BURST[15:0];
    can_present = (outs_next < MAX_O) && !cfg_dma_halt;
  end

  // Outstanding chunk counter; stray dones with nothing in flight are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) outs <= 4'd0;
    else     outs <= outs_next;
  end

  // Sequencing FSM with registered chunk command and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      xsize       <= 16'd0;
      sa_ystep    <= 16'd0;
      da_ystep    <= 16'd0;
      x_off       <= 16'd0;
      lines_left  <= 16'd0;
      line_src    <= 32'd0;
      line_dst    <= 32'd0;
      final_chunk <= 1'b0;
      ck.ck_valid <= 1'b0;
      ck.ck_src   <= 32'd0;
      ck.ck_dst   <= 32'd0;
      ck.ck_len   <= 16'd0;
      cmd_end     <= 1'b0;
      sched_busy  <= 1'b0;
    end else begin
      cmd_end <= 1'b0;
      case (state)
        S_IDLE: begin
          // busy covers the cmd_end cycle and falls right after it
          if (cmd_end) sched_busy <= 1'b0;
          if (cmd_sof) begin
            xsize       <= cfg_trans_xsize;
            sa_ystep    <= cfg_sa_ystep;
            da_ystep    <= cfg_da_ystep;
            line_src    <= cfg_sar;
            line_dst    <= cfg_dar;
            lines_left  <= cfg_trans_ysize;
            x_off       <= 16'd0;
            final_chunk <= 1'b0;
            sched_busy  <= 1'b1;
            if (cfg_trans_xsize == 16'd0 || cfg_trans_ysize == 16'd0) state <= S_END;
            else                                                        state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // A presented chunk is frozen until accepted; pointers already describe the next one.
          if (!ck.ck_valid || ck.ck_ready) begin
            if (xfer && final_chunk) begin
              ck.ck_valid <= 1'b0;
              state       <= S_DRAIN;
            end else if (can_present) begin
              ck.ck_valid <= 1'b1;
              ck.ck_src   <= line_src + {16'd0, x_off};
              ck.ck_dst   <= line_dst + {16'd0, x_off};
              ck.ck_len   <= len;
              final_chunk <= last_x && (lines_left == 16'd1);
              if (last_x) begin
                x_off      <= 16'd0;
                line_src   <= line_src + {16'd0, sa_ystep};
                line_dst   <= line_dst + {16'd0, da_ystep};
                lines_left <= lines_left - 16'd1;
              end else begin
                x_off <= x_off + len;
              end
            end else begin
              ck.ck_valid <= 1'b0;
            end
          end
        end
        S_DRAIN: begin
          if (outs_next == 4'd0) state <= S_END;
        end
        S_END: begin
          cmd_end <= 1'b1;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_2d_sched.sv
// Directed bench for dma_2d_sched with a chunk-list model: on each accepted
// start the model expands the 2D command into its expected chunk sequence,
// and every cycle the presented chunk, in-flight bound, busy and cmd_end
// behaviour are compared against it.
module tb_dma_2d_sched;
  localparam int BURST = 64;
  localparam int MAXO  = 4;

  typedef struct {
    logic [31:0] src;
    logic [31:0] dst;
    logic [15:0] len;
  } chunk_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_sof;
  logic [31:0] cfg_sar, cfg_dar;
  logic [15:0] cfg_trans_xsize, cfg_trans_ysize, cfg_sa_ystep, cfg_da_ystep;
  logic        cfg_dma_halt;
  logic        cmd_end, sched_busy;

  dma_2d_sched_if ck_if ();

  dma_2d_sched #(.BURST_BYTES(BURST), .MAX_OUTS(MAXO)) dut (
    .clk(clk), .rst(rst), .cmd_sof(cmd_sof),
    .cfg_sar(cfg_sar), .cfg_dar(cfg_dar),
    .cfg_trans_xsize(cfg_trans_xsize), .cfg_trans_ysize(cfg_trans_ysize),
    .cfg_sa_ystep(cfg_sa_ystep), .cfg_da_ystep(cfg_da_ystep),
    .cfg_dma_halt(cfg_dma_halt),
    .cmd_end(cmd_end), .sched_busy(sched_busy),
    .ck(ck_if)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  chunk_t exp_q[$];
  chunk_t log_q[$];
  int     due_q[$];
  int     due_idx = 0;
  int     out_m = 0;
  bit     busy_m = 0;
  bit     prev_pending = 0;
  bit     prev_halt = 0;
  int     cyc = 0;
  int     ends_cnt = 0;
  int     end_cyc = 0;
  int     sof_cyc = 0;
  int     done_mode = 0;   // 0 none, 1 three cycles after accept, 2 whenever chunks are in flight
  int     done_req = 0;
  int     done_served = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, want);
    end
  endtask

  // Expected chunk list of one 2D command, from the address/length rules.
  task automatic build(input logic [31:0] sar, input logic [31:0] dar, input int xs, input int ys,
                       input logic [15:0] ss, input logic [15:0] ds);
    for (int y = 0; y < ys; y++) begin
      int x = 0;
      while (x < xs) begin
        chunk_t c;
        int l = (xs - x > BURST) ? BURST : xs - x;
        c.src = sar + 32'(y) * {16'd0, ss} + 32'(x);
        c.dst = dar + 32'(y) * {16'd0, ds} + 32'(x);
        c.len = 16'(l);
        exp_q.push_back(c);
        x += l;
      end
    end
  endtask

  task automatic monitor();
    bit xfer;
    if (rst) begin
      chk("rst_valid", {63'd0, ck_if.ck_valid}, 0);
      chk("rst_end", {63'd0, cmd_end}, 0);
      chk("rst_busy", {63'd0, sched_busy}, 0);
      chk("rst_fields", {ck_if.ck_src, ck_if.ck_dst[15:0], ck_if.ck_len}, 0);
      exp_q.delete();
      out_m = 0; busy_m = 0; prev_pending = 0; prev_halt = 0;
      return;
    end
    chk("busy", {63'd0, sched_busy}, {63'd0, busy_m});
    if (ck_if.ck_valid) begin
      if (exp_q.size() == 0) chk("valid_without_chunk", 1, 0);
      else begin
        chk("ck_src", {32'd0, ck_if.ck_src}, {32'd0, exp_q[0].src});
        chk("ck_dst", {32'd0, ck_if.ck_dst}, {32'd0, exp_q[0].dst});
        chk("ck_len", {48'd0, ck_if.ck_len}, {48'd0, exp_q[0].len});
      end
      chk("outs_cap", {63'd0, out_m < MAXO}, 1);
      if (!prev_pending) chk("valid_after_halt", {63'd0, prev_halt}, 0);
    end else if (prev_pending) begin
      chk("valid_dropped", 0, 1);
    end
    xfer = ck_if.ck_valid && ck_if.ck_ready;
    if (xfer) begin
      chunk_t c;
      c.src = ck_if.ck_src; c.dst = ck_if.ck_dst; c.len = ck_if.ck_len;
      log_q.push_back(c);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      if (done_mode == 1) due_q.push_back(cyc + 3);
    end
    if (ck_if.ck_done && out_m > 0) out_m--;
    if (xfer) out_m++;
    if (cmd_end) begin
      chk("end_while_busy", {63'd0, busy_m}, 1);
      chk("end_chunks_left", 64'(exp_q.size()), 0);
      chk("end_outs", 64'(out_m), 0);
      ends_cnt++;
      end_cyc = cyc;
      busy_m = 0;
    end
    if (cmd_sof && !busy_m) begin
      busy_m = 1;
      sof_cyc = cyc;
      build(cfg_sar, cfg_dar, int'(cfg_trans_xsize), int'(cfg_trans_ysize), cfg_sa_ystep, cfg_da_ystep);
    end
    prev_pending = ck_if.ck_valid && !ck_if.ck_ready;
    prev_halt = cfg_dma_halt;
  endtask

  task automatic drive_done();
    ck_if.ck_done = 1'b0;
    if (done_mode == 1 && due_idx < due_q.size() && due_q[due_idx] <= cyc) begin
      ck_if.ck_done = 1'b1;
      due_idx++;
    end else if (done_mode == 2 && out_m > 0) begin
      ck_if.ck_done = 1'b1;
    end else if (done_served < done_req) begin
      ck_if.ck_done = 1'b1;
      done_served++;
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      monitor();
      @(posedge clk);
      cyc++;
      #1;
      drive_done();
    end
  endtask

  task automatic start_cmd(input logic [31:0] sar, input logic [31:0] dar, input logic [15:0] xs,
                           input logic [15:0] ys, input logic [15:0] ss, input logic [15:0] ds);
    cfg_sar = sar; cfg_dar = dar; cfg_trans_xsize = xs; cfg_trans_ysize = ys;
    cfg_sa_ystep = ss; cfg_da_ystep = ds;
    cmd_sof = 1'b1;
    tick();
    cmd_sof = 1'b0;
  endtask

  task automatic wait_end(input int budget);
    int start = ends_cnt;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (ends_cnt != start) break;
    end
    chk("end_seen", 64'(ends_cnt - start), 1);
  endtask

  initial begin
    rst = 1'b1; cmd_sof = 1'b0; cfg_dma_halt = 1'b0;
    cfg_sar = '0; cfg_dar = '0; cfg_trans_xsize = '0; cfg_trans_ysize = '0;
    cfg_sa_ystep = '0; cfg_da_ystep = '0;
    ck_if.ck_ready = 1'b0; ck_if.ck_done = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(2);

    // two full-burst lines, done three cycles after each accept
    done_mode = 1; ck_if.ck_ready = 1'b1; log_q.delete();
    start_cmd(32'h1000, 32'h8000, 16'd64, 16'd2, 16'h100, 16'h100);
    wait_end(60);
    chk("t1_count", 64'(log_q.size()), 2);
    if (log_q.size() == 2) begin
      chk("t1_c0", {log_q[0].src, log_q[0].dst[15:0], log_q[0].len}, {32'h1000, 16'h8000, 16'd64});
      chk("t1_c1", {log_q[1].src, log_q[1].dst[15:0], log_q[1].len}, {32'h1100, 16'h8100, 16'd64});
    end
    tick(4);
    chk("t1_single_end", 64'(ends_cnt), 1);

    // partial tail chunk
    log_q.delete();
    start_cmd(32'h4000, 32'h6000, 16'd150, 16'd1, 16'h0, 16'h0);
    wait_end(60);
    chk("t2_count", 64'(log_q.size()), 3);
    if (log_q.size() == 3) begin
      chk("t2_lens", {log_q[0].len, log_q[1].len, log_q[2].len}, {16'd0, 16'd64, 16'd64, 16'd22});
      chk("t2_src2", {32'd0, log_q[2].src}, 64'h4080);
      chk("t2_src1", {32'd0, log_q[1].src}, 64'h4040);
    end

    // in-flight limit with dones withheld
    done_mode = 0; log_q.delete();
    start_cmd(32'h0, 32'h10000, 16'd512, 16'd1, 16'h0, 16'h0);
    tick(20);
    chk("t3_cap_count", 64'(log_q.size()), 4);
    chk("t3_cap_valid", {63'd0, ck_if.ck_valid}, 0);
    done_req++;
    tick(10);
    chk("t3_one_more", 64'(log_q.size()), 5);
    chk("t3_valid_low", {63'd0, ck_if.ck_valid}, 0);
    done_mode = 2;
    wait_end(80);
    chk("t3_total", 64'(log_q.size()), 8);

    // halt while a chunk waits for ready
    done_mode = 1; ck_if.ck_ready = 1'b0; log_q.delete();
    start_cmd(32'h2000, 32'h3000, 16'd128, 16'd1, 16'h0, 16'h0);
    for (int i = 0; i < 10 && !ck_if.ck_valid; i++) tick();
    cfg_dma_halt = 1'b1;
    tick(5);
    chk("t4_held_valid", {63'd0, ck_if.ck_valid}, 1);
    chk("t4_held_src", {32'd0, ck_if.ck_src}, 64'h2000);
    ck_if.ck_ready = 1'b1;
    tick(7);
    chk("t4_one_accepted", 64'(log_q.size()), 1);
    chk("t4_halted_valid", {63'd0, ck_if.ck_valid}, 0);
    cfg_dma_halt = 1'b0;
    wait_end(60);
    chk("t4_total", 64'(log_q.size()), 2);
    if (log_q.size() == 2) chk("t4_src1", {32'd0, log_q[1].src}, 64'h2040);

    // zero-width command
    log_q.delete();
    start_cmd(32'h5000, 32'h5000, 16'd0, 16'd5, 16'h10, 16'h10);
    wait_end(10);
    chk("t5_end_latency", 64'(end_cyc - sof_cyc), 2);
    chk("t5_no_chunks", 64'(log_q.size()), 0);

    // start pulse while busy is ignored
    ck_if.ck_ready = 1'b0; log_q.delete();
    start_cmd(32'h3000, 32'h7000, 16'd64, 16'd1, 16'h0, 16'h0);
    tick(2);
    start_cmd(32'h9000, 32'hA000, 16'd128, 16'd3, 16'h200, 16'h200);
    tick();
    ck_if.ck_ready = 1'b1;
    wait_end(60);
    tick(5);
    chk("t5_busy_sof_count", 64'(log_q.size()), 1);
    if (log_q.size() == 1) chk("t5_busy_sof_src", {32'd0, log_q[0].src}, 64'h3000);
    chk("t5_ends", 64'(ends_cnt), 6);

    // source line pointer wraps past 2^32
    log_q.delete();
    start_cmd(32'hFFFF_FFC0, 32'h0, 16'd64, 16'd2, 16'h80, 16'h80);
    wait_end(60);
    chk("t6_count", 64'(log_q.size()), 2);
    if (log_q.size() == 2) chk("t6_wrap_src", {32'd0, log_q[1].src}, 64'h40);

    // reset in the middle of a command
    done_mode = 0; log_q.delete();
    start_cmd(32'h0, 32'h0, 16'd512, 16'd1, 16'h0, 16'h0);
    tick(8);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    done_req += 2;
    tick(10);
    chk("t7_no_end", 64'(ends_cnt), 7);
    chk("t7_busy", {63'd0, sched_busy}, 0);
    chk("t7_valid", {63'd0, ck_if.ck_valid}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/dma_2d_sched.md
DMA_2D_SCHED -- requirements
Module: dma_2d_sched

Interface
REQ-001 Parameter BURST_BYTES, default 64: max bytes per chunk command; power of two, 1..32768.
REQ-002 Parameter MAX_OUTS, default 4: max issued-but-not-done chunks; 1..15.
REQ-003 clk  in  1  single clock; all logic rising-edge.
REQ-004 rst  in  1  reset, asynchronous assert, active-high.
REQ-005 cmd_sof  in  1  one-cycle start pulse; samples all cfg_* inputs.
REQ-006 cfg_sar / cfg_dar  in  32 each  source / destination byte base address.
REQ-007 cfg_trans_xsize / cfg_trans_ysize  in  16 each  bytes per line / line count.
REQ-008 cfg_sa_ystep / cfg_da_ystep  in  16 each  source / destination byte offset between line starts.
REQ-009 cfg_dma_halt  in  1  level; 1 = stop issuing new chunks.
REQ-010 ck_valid  out  1 / ck_ready  in  1  chunk command handshake.
REQ-011 ck_src / ck_dst  out  32 each / ck_len  out  16  chunk source address, destination address, byte count.
REQ-012 ck_done  in  1  one-cycle pulse per completed chunk, in issue order.
REQ-013 cmd_end  out  1  one-cycle pulse when the whole 2D command has completed.
REQ-014 sched_busy  out  1  high from the cycle after an accepted cmd_sof through the cmd_end cycle.

Function
REQ-015 States: IDLE, ISSUE, DRAIN, END; two-bit encoding; no other states reachable.
REQ-016 IDLE: cmd_sof latches cfg_* into internal shadow registers; next state is ISSUE, or END if xsize==0 or ysize==0.
REQ-017 cmd_sof in any state other than IDLE is ignored; shadows are unchanged.
REQ-018 Line pointers: at start, line_src=sar and line_dst=dar; after each line's last chunk accept, line_src+=zero-extended sa_ystep and line_dst+=zero-extended da_ystep; sums are mod 2^32 (wrap, no error).
REQ-019 Chunk: ck_src=line_src+x_off, ck_dst=line_dst+x_off, ck_len=min(xsize-x_off, BURST_BYTES); x_off starts at 0 and advances by ck_len per accepted chunk; x_off resets to 0 at line end.
REQ-020 ck_valid is asserted in ISSUE only when outstanding<MAX_OUTS and cfg_dma_halt==0.
REQ-021 Once asserted, ck_valid and ck_src/ck_dst/ck_len hold stable until ck_ready; halt rising while ck_valid is high does not drop ck_valid.
REQ-022 Transfer occurs on ck_valid&ck_ready; the next chunk may be presented the following cycle (throughput 1 chunk/clk).
REQ-023 outstanding counter: +1 on transfer, -1 on ck_done, unchanged when both occur in one cycle.
REQ-024 ck_done while outstanding==0 is ignored; the counter does not underflow.
REQ-025 After the final chunk (last line, last x chunk) is accepted: ISSUE -> DRAIN.
REQ-026 DRAIN: when outstanding reaches 0 (including a same-cycle final ck_done), go to END.
REQ-027 END: cmd_end=1 for exactly one cycle; next state is IDLE; sched_busy drops the cycle after END.
REQ-028 Zero-size command: no chunk is issued; cmd_end pulses 2 cycles after cmd_sof.
REQ-029 Chunk total per command = ysize * ceil(xsize/BURST_BYTES); no chunk may have ck_len==0.
REQ-030 Halt while in DRAIN has no effect; outstanding chunks still complete.

Reset
REQ-031 With rst high: state=IDLE; ck_valid=0, cmd_end=0, sched_busy=0, ck_src=0, ck_dst=0, ck_len=0; counters and shadows=0.
REQ-032 rst asserted mid-command aborts it immediately: no cmd_end is produced; ck_done pulses after reset release are ignored per REQ-024.

Verification
REQ-033 sar=0x1000, dar=0x8000, xsize=64, ysize=2, steps=0x100, ck_ready=1, ck_done 3 clk after each accept -> chunks (0x1000,0x8000,64), (0x1100,0x8100,64); one cmd_end.
REQ-034 xsize=150, ysize=1, BURST=64 -> ck_len 64, 64, 22 with ck_src offsets +0, +64, +128.
REQ-035 ck_done withheld, ck_ready=1 -> exactly 4 chunks issued, ck_valid low; one ck_done -> exactly one more chunk issued.
REQ-036 Halt=1 while ck_valid high with ck_ready=0 -> ck_valid and fields stay stable; ck_ready=1 -> accepted; no new ck_valid until halt=0.
REQ-037 xsize=0, ysize=5 -> no ck_valid; cmd_end 2 clk after sof. Second sof while busy -> ignored.
REQ-038 sar=0xFFFF_FFC0, sa_ystep=0x80, ysize=2 -> second line ck_src=0x0000_0040 (wrap).
